// File: rtl/vga_pkg.sv
// Shared VGA timing constants for the standard modes, the per-position sync/active flags
// carried down the display pipeline, and helpers that derive line/frame totals.
package vga_pkg;

  // 1280x1024 @ 60 Hz, 108 MHz pixel clock, positive syncs
  localparam int SXGA_H_ACTIVE = 1280;
  localparam int SXGA_H_FP     = 48;
  localparam int SXGA_H_SYNC   = 112;
  localparam int SXGA_H_BP     = 248;
  localparam int SXGA_V_ACTIVE = 1024;
  localparam int SXGA_V_FP     = 1;
  localparam int SXGA_V_SYNC   = 3;
  localparam int SXGA_V_BP     = 38;
  localparam bit SXGA_HS_POL   = 1'b1;
  localparam bit SXGA_VS_POL   = 1'b1;

  // 640x480 @ 60 Hz, 25.175 MHz pixel clock, negative syncs
  localparam int VGA_H_ACTIVE  = 640;
  localparam int VGA_H_FP      = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BP      = 48;
  localparam int VGA_V_ACTIVE  = 480;
  localparam int VGA_V_FP      = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BP      = 33;
  localparam bit VGA_HS_POL    = 1'b0;
  localparam bit VGA_VS_POL    = 1'b0;

  typedef struct packed {
    logic act;
    logic hs;
    logic vs;
  } vga_flags_t;

  localparam int FLAGS_W = $bits(vga_flags_t);

  function automatic int vga_total(int sync_w, int bp_w, int active_w, int fp_w);
    return sync_w + bp_w + active_w + fp_w;
  endfunction

  // First counter value of the visible area: sync and back porch precede it
  function automatic int vga_act_lo(int sync_w, int bp_w);
    return sync_w + bp_w;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Fetch-side and connector-side signals of the VGA timing generator.
interface vga_timing_gen_if #(
  parameter int RGB_W = 3,
  parameter int CW    = 12
);

  logic [RGB_W-1:0] rgb_data;
  logic             pix_req;
  logic [CW-1:0]    pix_x;
  logic [CW-1:0]    pix_y;
  logic             line_start;
  logic             frame_start;
  logic [RGB_W-1:0] VGA_rgb;
  logic             VGA_hsync;
  logic             VGA_vsync;

  modport master (
    input  rgb_data,
    output pix_req,
    output pix_x,
    output pix_y,
    output line_start,
    output frame_start,
    output VGA_rgb,
    output VGA_hsync,
    output VGA_vsync
  );

  modport slave (
    output rgb_data,
    input  pix_req,
    input  pix_x,
    input  pix_y,
    input  line_start,
    input  frame_start,
    input  VGA_rgb,
    input  VGA_hsync,
    input  VGA_vsync
  );

endinterface

// File: rtl/vga_sync_delay.sv
// Enable-gated shift register; aligns the raster flags with colour data returning from the fetch path.
module vga_sync_delay #(
  parameter int               WIDTH   = 3,
  parameter int               DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_p [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_p[i] <= RST_VAL;
      end
    end else if (en) begin
      stage_p[0] <= d;
      for (int i = 1; i < DEPTH; i++) begin
        stage_p[i] <= stage_p[i-1];
      end
    end
  end

  assign q = stage_p[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Programmable VGA raster generator: pixel-tick divider, h/v counters, a registered fetch request
// issued FETCH_LAT ticks ahead of display, and syncs delayed to stay aligned with the returned colour.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE  = SXGA_H_ACTIVE,
  parameter int H_FP      = SXGA_H_FP,
  parameter int H_SYNC    = SXGA_H_SYNC,
  parameter int H_BP      = SXGA_H_BP,
  parameter int V_ACTIVE  = SXGA_V_ACTIVE,
  parameter int V_FP      = SXGA_V_FP,
  parameter int V_SYNC    = SXGA_V_SYNC,
  parameter int V_BP      = SXGA_V_BP,
  parameter bit HS_POL    = SXGA_HS_POL,
  parameter bit VS_POL    = SXGA_VS_POL,
  parameter int PIX_DIV   = 1,
  parameter int FETCH_LAT = 2,
  parameter int RGB_W     = 3,
  parameter int CW        = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  vga_timing_gen_if.master vga
);

  localparam int H_TOTAL = vga_total(H_SYNC, H_BP, H_ACTIVE, H_FP);
  localparam int V_TOTAL = vga_total(V_SYNC, V_BP, V_ACTIVE, V_FP);

  localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT_LO   = CW'(vga_act_lo(H_SYNC, H_BP));
  localparam logic [CW-1:0] H_ACT_HI   = CW'(vga_act_lo(H_SYNC, H_BP) + H_ACTIVE);
  localparam logic [CW-1:0] V_ACT_LO   = CW'(vga_act_lo(V_SYNC, V_BP));
  localparam logic [CW-1:0] V_ACT_HI   = CW'(vga_act_lo(V_SYNC, V_BP) + V_ACTIVE);
  localparam logic [CW-1:0] H_SYNC_END = CW'(H_SYNC);
  localparam logic [CW-1:0] V_SYNC_END = CW'(V_SYNC);

  localparam int            DW       = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);

  logic [DW-1:0]      div_cnt;
  logic               tick;
  logic [CW-1:0]      hcount;
  logic [CW-1:0]      vcount;
  logic [CW-1:0]      h_next;
  logic [CW-1:0]      v_next;
  logic               h_wrap;
  logic               v_wrap;
  vga_flags_t         flags_p0;
  vga_flags_t         flags_pd;
  logic [FLAGS_W-1:0] flags_pd_raw;

  // Pixel tick: the PIX_DIV-th clk after reset is the first tick
  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + DW'(1);
    end
  end

  // Next raster position; request and pipeline entry both describe this position
  assign h_wrap = (hcount == H_LAST);
  assign v_wrap = (vcount == V_LAST);
  assign h_next = h_wrap ? '0 : hcount + CW'(1);
  assign v_next = h_wrap ? (v_wrap ? '0 : vcount + CW'(1)) : vcount;

  always_comb begin
    flags_p0.act = (h_next >= H_ACT_LO) && (h_next < H_ACT_HI) &&
                   (v_next >= V_ACT_LO) && (v_next < V_ACT_HI);
    flags_p0.hs  = (h_next < H_SYNC_END);
    flags_p0.vs  = (v_next < V_SYNC_END);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcount <= H_LAST;
      vcount <= V_LAST;
    end else if (tick) begin
      hcount <= h_next;
      vcount <= v_next;
    end
  end

  // Request stage: pulses last one clk, coordinates hold until the next active position
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga.pix_req     <= 1'b0;
      vga.line_start  <= 1'b0;
      vga.frame_start <= 1'b0;
      vga.pix_x       <= '0;
      vga.pix_y       <= '0;
    end else begin
      vga.pix_req     <= tick && flags_p0.act;
      vga.line_start  <= tick && h_wrap;
      vga.frame_start <= tick && h_wrap && v_wrap;
      if (tick && flags_p0.act) begin
        vga.pix_x <= h_next - H_ACT_LO;
        vga.pix_y <= v_next - V_ACT_LO;
      end
    end
  end

  vga_sync_delay #(
    .WIDTH   (FLAGS_W),
    .DEPTH   (FETCH_LAT),
    .RST_VAL ('0)
  ) u_sync_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (tick),
    .d     (flags_p0),
    .q     (flags_pd_raw)
  );

  assign flags_pd = vga_flags_t'(flags_pd_raw);

  // Display stage: colour and syncs leave together, FETCH_LAT ticks after their request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga.VGA_rgb   <= '0;
      vga.VGA_hsync <= ~HS_POL;
      vga.VGA_vsync <= ~VS_POL;
    end else if (tick) begin
      vga.VGA_rgb   <= flags_pd.act ? vga.rgb_data : '0;
      vga.VGA_hsync <= flags_pd.hs ? HS_POL : ~HS_POL;
      vga.VGA_vsync <= flags_pd.vs ? VS_POL : ~VS_POL;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two small-raster instances (PIX_DIV 1 and 3) and one default-timing
// instance with negative syncs, each compared every clk against a closed-form raster model.
module tb_vga_timing_gen;

  localparam int FL = 2;

  typedef struct { int hsy; int hbp; int hac; int hfp; int vsy; int vbp; int vac; int vfp; } tim_t;
  typedef struct { int fs; int ls; int req; int px; int py; int rgb; int hs; int vs; } exp_t;
  typedef struct { int k; int due; int val; } rq_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  vga_timing_gen_if #(.RGB_W(3), .CW(12)) bus0 ();
  vga_timing_gen_if #(.RGB_W(3), .CW(12)) bus1 ();
  vga_timing_gen_if #(.RGB_W(3), .CW(12)) bus2 ();

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .PIX_DIV(1), .FETCH_LAT(FL), .RGB_W(3), .CW(12)
  ) dut0 (.clk(clk), .rst_n(rst_n), .vga(bus0));

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b0), .PIX_DIV(3), .FETCH_LAT(FL), .RGB_W(3), .CW(12)
  ) dut1 (.clk(clk), .rst_n(rst_n), .vga(bus1));

  vga_timing_gen #(
    .HS_POL(1'b0), .VS_POL(1'b0), .PIX_DIV(1), .FETCH_LAT(FL), .RGB_W(3), .CW(12)
  ) dut2 (.clk(clk), .rst_n(rst_n), .vga(bus2));

  logic [2:0]  rgb_drv [3];
  logic        fs_o [3];
  logic        ls_o [3];
  logic        req_o [3];
  logic        hs_o [3];
  logic        vs_o [3];
  logic [11:0] px_o [3];
  logic [11:0] py_o [3];
  logic [2:0]  rgb_o [3];

  assign bus0.rgb_data = rgb_drv[0];
  assign bus1.rgb_data = rgb_drv[1];
  assign bus2.rgb_data = rgb_drv[2];

  assign fs_o[0] = bus0.frame_start;  assign fs_o[1] = bus1.frame_start;  assign fs_o[2] = bus2.frame_start;
  assign ls_o[0] = bus0.line_start;   assign ls_o[1] = bus1.line_start;   assign ls_o[2] = bus2.line_start;
  assign req_o[0] = bus0.pix_req;     assign req_o[1] = bus1.pix_req;     assign req_o[2] = bus2.pix_req;
  assign hs_o[0] = bus0.VGA_hsync;    assign hs_o[1] = bus1.VGA_hsync;    assign hs_o[2] = bus2.VGA_hsync;
  assign vs_o[0] = bus0.VGA_vsync;    assign vs_o[1] = bus1.VGA_vsync;    assign vs_o[2] = bus2.VGA_vsync;
  assign px_o[0] = bus0.pix_x;        assign px_o[1] = bus1.pix_x;        assign px_o[2] = bus2.pix_x;
  assign py_o[0] = bus0.pix_y;        assign py_o[1] = bus1.pix_y;        assign py_o[2] = bus2.pix_y;
  assign rgb_o[0] = bus0.VGA_rgb;     assign rgb_o[1] = bus1.VGA_rgb;     assign rgb_o[2] = bus2.VGA_rgb;

  tim_t tims [3];
  int   divs [3] = '{1, 3, 1};
  bit   hpol [3] = '{1'b1, 1'b1, 1'b0};
  bit   vpol [3] = '{1'b1, 1'b0, 1'b0};

  int  n_chk = 0;
  int  n_pass = 0;
  int  e = 0;
  rq_t rq[$];

  int last_fs0, reqs0, first_req0, last_fs1, hlow, vlow;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    else n_pass++;
  endtask

  function automatic int colour(int x, int y);
    return ((x + 3 * y) % 7) + 1;
  endfunction

  function automatic bit is_act(tim_t t, int h, int v);
    return (h >= t.hsy + t.hbp) && (h < t.hsy + t.hbp + t.hac) &&
           (v >= t.vsy + t.vbp) && (v < t.vsy + t.vbp + t.vac);
  endfunction

  // Coordinates of the most recent active position at or before raster index p
  function automatic void last_xy(input tim_t t, input int p, output int x, output int y);
    int ht, vt, h, v, h0, v0;
    ht = t.hsy + t.hbp + t.hac + t.hfp;
    vt = t.vsy + t.vbp + t.vac + t.vfp;
    h  = p % ht;
    v  = (p / ht) % vt;
    h0 = t.hsy + t.hbp;
    v0 = t.vsy + t.vbp;
    x  = 0;
    y  = 0;
    if (v >= v0 && v < v0 + t.vac && h >= h0) begin
      x = (h - h0 < t.hac) ? h - h0 : t.hac - 1;
      y = v - v0;
    end else if (v > v0 && v < v0 + t.vac) begin
      x = t.hac - 1;
      y = v - 1 - v0;
    end else if (v >= v0 + t.vac || p >= ht * vt) begin
      x = t.hac - 1;
      y = t.vac - 1;
    end
  endfunction

  // Expected outputs after the e-th rising edge since reset release (e=0: in reset)
  function automatic exp_t model(tim_t t, int d, bit hp, bit vp, int ev);
    exp_t r;
    int ht, vt, n, p, q, h, v, x, y;
    bit tk;
    ht = t.hsy + t.hbp + t.hac + t.hfp;
    vt = t.vsy + t.vbp + t.vac + t.vfp;
    n  = ev / d;
    tk = (ev > 0) && (ev % d == 0);
    r  = '{default: 0};
    r.hs = int'(!hp);
    r.vs = int'(!vp);
    if (n >= 1) begin
      p = n - 1;
      h = p % ht;
      v = (p / ht) % vt;
      r.fs  = int'(tk && h == 0 && v == 0);
      r.ls  = int'(tk && h == 0);
      r.req = int'(tk && is_act(t, h, v));
      last_xy(t, p, x, y);
      r.px = x;
      r.py = y;
    end
    q = n - 1 - FL;
    if (q >= 0) begin
      h = q % ht;
      v = (q / ht) % vt;
      if (h < t.hsy) r.hs = int'(hp);
      if (v < t.vsy) r.vs = int'(vp);
      if (is_act(t, h, v)) begin
        last_xy(t, q, x, y);
        r.rgb = colour(x, y);
      end
    end
    return r;
  endfunction

  task automatic check_dut(input int k);
    exp_t m;
    m = model(tims[k], divs[k], hpol[k], vpol[k], e);
    chk($sformatf("d%0d.frame_start@%0d", k, e), 32'(fs_o[k]), 32'(m.fs));
    chk($sformatf("d%0d.line_start@%0d", k, e), 32'(ls_o[k]), 32'(m.ls));
    chk($sformatf("d%0d.pix_req@%0d", k, e), 32'(req_o[k]), 32'(m.req));
    chk($sformatf("d%0d.pix_x@%0d", k, e), 32'(px_o[k]), 32'(m.px));
    chk($sformatf("d%0d.pix_y@%0d", k, e), 32'(py_o[k]), 32'(m.py));
    chk($sformatf("d%0d.VGA_rgb@%0d", k, e), 32'(rgb_o[k]), 32'(m.rgb));
    chk($sformatf("d%0d.VGA_hsync@%0d", k, e), 32'(hs_o[k]), 32'(m.hs));
    chk($sformatf("d%0d.VGA_vsync@%0d", k, e), 32'(vs_o[k]), 32'(m.vs));
  endtask

  // Fetch-side model: answers each request with colour(x,y), valid for the edge FL ticks later
  task automatic serve();
    rq_t keep[$];
    rq_t r;
    for (int k = 0; k < 3; k++) begin
      if (req_o[k]) begin
        r.k   = k;
        r.due = e + FL * divs[k];
        r.val = colour(int'(px_o[k]), int'(py_o[k]));
        rq.push_back(r);
      end
      rgb_drv[k] = 3'h7;
    end
    foreach (rq[i]) begin
      if (rq[i].due == e + 1) rgb_drv[rq[i].k] = 3'(rq[i].val);
      else if (rq[i].due > e + 1) keep.push_back(rq[i]);
    end
    rq = keep;
  endtask

  task automatic track();
    if (fs_o[0]) begin
      if (last_fs0 > 0) begin
        chk("d0.frame_period", 32'(e - last_fs0), 32'd48);
        chk("d0.req_per_frame", 32'(reqs0), 32'd12);
      end
      last_fs0 = e;
      reqs0    = 0;
    end
    if (req_o[0]) begin
      reqs0++;
      if (first_req0 < 0) first_req0 = e;
    end
    if (fs_o[1]) begin
      if (last_fs1 > 0) chk("d1.frame_period", 32'(e - last_fs1), 32'd144);
      last_fs1 = e;
    end
    if (e >= 3 && e <= 3 + 1687 && !hs_o[2]) hlow++;
    if (e >= 3 && !vs_o[2]) vlow++;
  endtask

  task automatic step();
    @(posedge clk);
    e++;
    #1;
    serve();
    @(negedge clk);
    for (int k = 0; k < 3; k++) check_dut(k);
    track();
  endtask

  task automatic release_reset();
    rq.delete();
    for (int k = 0; k < 3; k++) rgb_drv[k] = 3'h7;
    e          = 0;
    last_fs0   = 0;
    reqs0      = 0;
    first_req0 = -1;
    last_fs1   = 0;
    hlow       = 0;
    vlow       = 0;
    rst_n      = 1'b1;
  endtask

  initial begin
    exp_t m;
    bit   found;
    tims[0] = '{2, 1, 4, 1, 1, 1, 3, 1};
    tims[1] = '{2, 1, 4, 1, 1, 1, 3, 1};
    tims[2] = '{112, 248, 1280, 48, 3, 38, 1024, 1};
    for (int k = 0; k < 3; k++) rgb_drv[k] = 3'h7;

    // Power-on reset, checked before any clock edge and again after a few edges
    #1 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) check_dut(k);
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) check_dut(k);

    release_reset();
    for (int i = 0; i < 450; i++) step();
    chk("d0.first_req_edge", 32'(first_req0), 32'd20);

    // Advance until dut0 is showing an active pixel, then reset between clock edges
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      m = model(tims[0], 1, 1'b1, 1'b1, e);
      if (m.rgb != 0 && e % 8 != 6) found = 1'b1;
      else step();
    end
    chk("mid_line_found", 32'(found), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    e = 0;
    for (int k = 0; k < 3; k++) check_dut(k);
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) check_dut(k);

    release_reset();
    for (int i = 0; i < 5200; i++) step();
    chk("d0.first_req_edge_after_reset", 32'(first_req0), 32'd20);
    chk("d2.hsync_low_ticks_per_line", 32'(hlow), 32'd112);
    chk("d2.vsync_low_ticks", 32'(vlow), 32'(3 * 1688));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
